zero_cross_det: RTL and testbench

Zero-crossing edge classifier. Runs after the Laplacian intensity-gradient stage has filled the gradient frame buffer. Scans that buffer in raster order through its 3x3 window read port. Writes a 1-bit edge map to the edge frame buffer and reports the total edge count.

---
 rtl/zc_pkg.sv | 38 +++
 rtl/zero_cross_det_if.sv | 38 +++
 rtl/zc_classify.sv | 40 ++++
 rtl/zero_cross_det.sv | 173 +++++++++++++++++
 tb/tb_zero_cross_det.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/zc_pkg.sv
// Shared definitions for the zero-crossing edge classifier.
//   - zc_state_e : scan FSM states
//   - window geometry of the 3x3 gradient read port and flat-vector element indexing
//   - indices of the centre sample and its four edge-adjacent neighbours
package zc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDrain,
      StDone
   } zc_state_e;

   localparam int unsigned WIN_DIM  = 3;
   localparam int unsigned WIN_SIZE = WIN_DIM * WIN_DIM;

   // Element [y][x] of the window sits at element index y*3+x of the flat vector.
   function automatic int unsigned win_idx(input int unsigned y, input int unsigned x);
      return y * WIN_DIM + x;
   endfunction

   localparam int unsigned IDX_C   = win_idx(1, 1);
   localparam int unsigned IDX_N   = win_idx(0, 1);
   localparam int unsigned IDX_W   = win_idx(1, 0);
   localparam int unsigned IDX_E   = win_idx(1, 2);
   localparam int unsigned IDX_S   = win_idx(2, 1);
   localparam int unsigned NUM_NBR = 4;

   function automatic int unsigned nbr_idx(input int unsigned k);
      case (k)
         0:       return IDX_N;
         1:       return IDX_W;
         2:       return IDX_E;
         default: return IDX_S;
      endcase
   endfunction

endpackage

// File: rtl/zero_cross_det_if.sv
// Control and frame-buffer bus of zero_cross_det.
//   start/thresh          : frame launch and crossing threshold
//   busy/done/edge_cnt    : status
//   rd_en/rd_x/rd_y       : gradient buffer 3x3 window read request
//   rd_data_flat          : window returned the cycle after rd_en
//   wr_en/wr_x/wr_y/wr_data : edge-map write port
// modport master : the classifier (drives buffer requests and status)
// modport slave  : the environment (controller plus both frame buffers)
interface zero_cross_det_if #(
   parameter int unsigned COORD_BITS = 6,
   parameter int unsigned PXL_BITS   = 12
) ();

   logic                    start;
   logic [PXL_BITS-1:0]     thresh;
   logic                    busy;
   logic                    done;
   logic [2*COORD_BITS-1:0] edge_cnt;
   logic                    rd_en;
   logic [COORD_BITS-1:0]   rd_x;
   logic [COORD_BITS-1:0]   rd_y;
   logic [9*PXL_BITS-1:0]   rd_data_flat;
   logic                    wr_en;
   logic [COORD_BITS-1:0]   wr_x;
   logic [COORD_BITS-1:0]   wr_y;
   logic                    wr_data;

   modport master (
      input  start, thresh, rd_data_flat,
      output busy, done, edge_cnt, rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data
   );

   modport slave (
      output start, thresh, rd_data_flat,
      input  busy, done, edge_cnt, rd_en, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data
   );

endinterface

// File: rtl/zc_classify.sv
// Combinational zero-crossing test on one 3x3 gradient window.
//   win_i    : flat window, element [y][x] at bits (y*3+x)*PXL_BITS
//   thresh_i : unsigned crossing threshold
//   edge_o   : 1 when any edge-adjacent neighbour has the opposite sign to the
//              centre and differs from it by more than thresh_i
// Border suppression is not done here; the parent owns the coordinates.
module zc_classify
   import zc_pkg::*;
#(
   parameter int unsigned PXL_BITS = 12
) (
   input  logic [WIN_SIZE*PXL_BITS-1:0] win_i,
   input  logic [PXL_BITS-1:0]          thresh_i,
   output logic                         edge_o
);

   logic [PXL_BITS-1:0] c;
   logic [PXL_BITS-1:0] n;
   logic [PXL_BITS:0]   diff;
   logic [PXL_BITS:0]   mag;

   always_comb begin
      c      = win_i[IDX_C*PXL_BITS +: PXL_BITS];
      n      = '0;
      diff   = '0;
      mag    = '0;
      edge_o = 1'b0;
      for (int unsigned k = 0; k < NUM_NBR; k++) begin
         n    = win_i[nbr_idx(k)*PXL_BITS +: PXL_BITS];
         // One extra bit keeps c - n exact across the full signed sample range.
         diff = {c[PXL_BITS-1], c} - {n[PXL_BITS-1], n};
         mag  = diff[PXL_BITS] ? (~diff + (PXL_BITS+1)'(1)) : diff;
         // Sign bits differ <=> one sample negative, the other zero or positive.
         if ((c[PXL_BITS-1] != n[PXL_BITS-1]) && (mag > {1'b0, thresh_i})) begin
            edge_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/zero_cross_det.sv
// Zero-crossing edge classifier top.
// Scans the gradient frame buffer in raster order (one window read per cycle),
// classifies each centre pixel and writes a 1-bit edge map, counting edges.
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset; aborts a frame in flight
//   bus : zero_cross_det_if.master (start/thresh, status, read and write ports)
// Pipeline: read issued in cycle t, window returns in t+1 and is classified
// combinationally, wr_* registered and visible in t+2.
module zero_cross_det
   import zc_pkg::*;
#(
   parameter int unsigned IMG_WD     = 64,
   parameter int unsigned IMG_HT     = 64,
   parameter int unsigned COORD_BITS = 6,
   parameter int unsigned PXL_BITS   = 12
) (
   input  logic             clk,
   input  logic             rst,
   zero_cross_det_if.master bus
);

   localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IMG_WD - 1);
   localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IMG_HT - 1);

   zc_state_e               state_q, state_d;
   logic                    drain_q, drain_d;
   logic [COORD_BITS-1:0]   x_q, x_d;
   logic [COORD_BITS-1:0]   y_q, y_d;
   logic [PXL_BITS-1:0]     thresh_q, thresh_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    rd_en_q, rd_en_d;
   // Stage 1: coordinates of the read whose window is on rd_data_flat now.
   logic                    s1_valid_q, s1_valid_d;
   logic [COORD_BITS-1:0]   s1_x_q, s1_x_d;
   logic [COORD_BITS-1:0]   s1_y_q, s1_y_d;
   // Stage 2: registered write port.
   logic                    wr_en_q, wr_en_d;
   logic [COORD_BITS-1:0]   wr_x_q, wr_x_d;
   logic [COORD_BITS-1:0]   wr_y_q, wr_y_d;
   logic                    wr_data_q, wr_data_d;
   logic [2*COORD_BITS-1:0] cnt_q, cnt_d;

   logic edge_raw;
   logic border;

   zc_classify #(
      .PXL_BITS (PXL_BITS)
   ) u_classify (
      .win_i    (bus.rd_data_flat),
      .thresh_i (thresh_q),
      .edge_o   (edge_raw)
   );

   assign border = (s1_x_q == '0) || (s1_x_q == X_LAST) ||
                   (s1_y_q == '0) || (s1_y_q == Y_LAST);

   always_comb begin
      state_d    = state_q;
      drain_d    = drain_q;
      x_d        = x_q;
      y_d        = y_q;
      thresh_d   = thresh_q;
      cnt_d      = cnt_q;

      s1_valid_d = (state_q == StScan);
      s1_x_d     = (state_q == StScan) ? x_q : s1_x_q;
      s1_y_d     = (state_q == StScan) ? y_q : s1_y_q;

      wr_en_d    = s1_valid_q;
      wr_x_d     = s1_valid_q ? s1_x_q : wr_x_q;
      wr_y_d     = s1_valid_q ? s1_y_q : wr_y_q;
      wr_data_d  = s1_valid_q & edge_raw & ~border;

      if (wr_en_q && wr_data_q && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d  = StScan;
               thresh_d = bus.thresh;
               cnt_d    = '0;
               x_d      = '0;
               y_d      = '0;
            end
         end
         StScan: begin
            if (x_q == X_LAST) begin
               x_d = '0;
               if (y_q == Y_LAST) begin
                  y_d     = '0;
                  drain_d = 1'b0;
                  state_d = StDrain;
               end else begin
                  y_d = y_q + 1'b1;
               end
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         StDrain: begin
            // Two cycles let the last read reach the write port.
            drain_d = 1'b1;
            if (drain_q) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Status outputs are registered from the next state.
      busy_d  = (state_d == StScan) || (state_d == StDrain);
      done_d  = (state_d == StDone);
      rd_en_d = (state_d == StScan);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         drain_q    <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         thresh_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_x_q     <= '0;
         wr_y_q     <= '0;
         wr_data_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         x_q        <= x_d;
         y_q        <= y_d;
         thresh_q   <= thresh_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
         s1_valid_q <= s1_valid_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         wr_en_q    <= wr_en_d;
         wr_x_q     <= wr_x_d;
         wr_y_q     <= wr_y_d;
         wr_data_q  <= wr_data_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.edge_cnt = cnt_q;
   assign bus.rd_en    = rd_en_q;
   assign bus.rd_x     = x_q;
   assign bus.rd_y     = y_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_x     = wr_x_q;
   assign bus.wr_y     = wr_y_q;
   assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_zero_cross_det.sv
// Scoreboard bench for zero_cross_det on a 4x4 image.
module tb_zero_cross_det;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int CB = 6;
   localparam int PB = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   zero_cross_det_if #(.COORD_BITS(CB), .PXL_BITS(PB)) bus ();

   zero_cross_det #(
      .IMG_WD     (W),
      .IMG_HT     (H),
      .COORD_BITS (CB),
      .PXL_BITS   (PB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int c;
      int x;
      int y;
      int d;
   } exp_t;

   exp_t rd_q[$];
   exp_t wr_q[$];
   exp_t dn_q[$];

   logic [PB-1:0] grad [N];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input longint got, input longint req);
      n_checks++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, req, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: strobe seen at cycle %0d, required none", name, cyc);
   endtask

   function automatic logic [9*PB-1:0] window(input int x, input int y);
      logic [9*PB-1:0] w;
      int px;
      int py;
      w = '0;
      for (int yy = 0; yy < 3; yy++) begin
         for (int xx = 0; xx < 3; xx++) begin
            px = x + xx - 1;
            py = y + yy - 1;
            if (px >= 0 && px < W && py >= 0 && py < H) begin
               w[(yy*3+xx)*PB +: PB] = grad[py*W+px];
            end
         end
      end
      return w;
   endfunction

   // Gradient frame buffer: window valid the cycle after rd_en.
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data_flat <= window(int'(bus.rd_x), int'(bus.rd_y));
   end

   // Monitor: pops the expected transaction whenever the DUT presents one.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.rd_en) begin
            if (rd_q.size() == 0) unexpected("rd_en");
            else begin
               e = rd_q.pop_front();
               chk("rd_cycle", cyc, e.c);
               chk("rd_x", bus.rd_x, e.x);
               chk("rd_y", bus.rd_y, e.y);
            end
         end
         if (bus.wr_en) begin
            if (wr_q.size() == 0) unexpected("wr_en");
            else begin
               e = wr_q.pop_front();
               chk("wr_cycle", cyc, e.c);
               chk("wr_x", bus.wr_x, e.x);
               chk("wr_y", bus.wr_y, e.y);
               chk("wr_data", bus.wr_data, e.d);
               chk("busy_in_write", bus.busy, 1);
            end
         end
         if (bus.done) begin
            if (dn_q.size() == 0) unexpected("done");
            else begin
               e = dn_q.pop_front();
               chk("done_cycle", cyc, e.c);
               chk("done_edge_cnt", bus.edge_cnt, e.d);
               chk("busy_at_done", bus.busy, 0);
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_rd_en"}, bus.rd_en, 0);
      chk({tag, "_rd_xy"}, {bus.rd_x, bus.rd_y}, 0);
      chk({tag, "_wr_en"}, bus.wr_en, 0);
      chk({tag, "_wr_data"}, bus.wr_data, 0);
      chk({tag, "_wr_xy"}, {bus.wr_x, bus.wr_y}, 0);
      chk({tag, "_edge_cnt"}, bus.edge_cnt, 0);
   endtask

   // kind 0: all zero; 1: +100 with (2,1)=-50; 2: +2047 with (1,1)=-2048
   task automatic set_frame(input int kind);
      int v;
      for (int i = 0; i < N; i++) begin
         case (kind)
            1:       v = (i == 6) ? -50 : 100;
            2:       v = (i == 5) ? -2048 : 2047;
            default: v = 0;
         endcase
         grad[i] = PB'(v);
      end
   endtask

   // One frame; rst_at / repulse_at are cycles after start (0 = none).
   task automatic run_frame(input int thr, input logic [N-1:0] mask, input int exp_cnt,
                            input int rst_at, input int repulse_at);
      exp_t e;
      int   s0;
      int   t;
      @(negedge clk);
      s0         = cyc;
      t          = thr;
      bus.start  = 1'b1;
      bus.thresh = t[PB-1:0];
      for (int i = 0; i < N; i++) begin
         e.c = s0 + 1 + i;
         e.x = i % W;
         e.y = i / W;
         e.d = 0;
         rd_q.push_back(e);
         e.c = s0 + 3 + i;
         e.d = int'(mask[i]);
         wr_q.push_back(e);
      end
      e.c = s0 + N + 3;
      e.x = 0;
      e.y = 0;
      e.d = exp_cnt;
      dn_q.push_back(e);
      for (int k = 1; k <= N + 12; k++) begin
         @(negedge clk);
         if (k == rst_at + 1) rst = 1'b0;
         t          = (k == repulse_at) ? thr + 1 : thr;
         bus.start  = (k == repulse_at);
         bus.thresh = t[PB-1:0];
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            check_all_zero("rst_mid");
            rd_q.delete();
            wr_q.delete();
            dn_q.delete();
         end
      end
      bus.start = 1'b0;
      chk("pending_reads", rd_q.size(), 0);
      chk("pending_writes", wr_q.size(), 0);
      chk("pending_done", dn_q.size(), 0);
      chk("edge_cnt_hold", bus.edge_cnt, exp_cnt);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.thresh = '0;
      set_frame(0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      set_frame(0);
      run_frame(0, 16'h0000, 0, 0, 0);
      set_frame(1);
      run_frame(149, 16'h0460, 3, 0, 0);
      run_frame(150, 16'h0000, 0, 0, 0);
      set_frame(2);
      run_frame(4094, 16'h0260, 3, 0, 0);
      set_frame(1);
      run_frame(149, 16'h0460, 0, 8, 0);
      run_frame(149, 16'h0460, 3, 0, 0);
      run_frame(149, 16'h0460, 3, 0, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
